// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder: funct3 encodings,
// FSM state encoding and the latched request record.
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   // Width of the latched address field; the responder's DM_ADDRESS defaults to it.
   localparam int DMEM_ADDR_W = 9;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } dmem_state_t;

   typedef struct packed {
      logic                   is_write;
      logic [DMEM_ADDR_W-1:0] addr;
      logic [31:0]            wdata;
      logic [2:0]             func3;
   } dmem_req_t;

   function automatic logic is_reserved_f3(input logic [2:0] f3);
      return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
   endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Byte-lane formatter: store byte-enables and replicated store word, plus
// load extraction with sign/zero extension selected by funct3.
module dmem_lane_fmt
   import dmem_pkg::*;
(
   input  logic [1:0]  offset,
   input  logic [2:0]  func3,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  be,
   output logic [31:0] st_word,
   output logic [31:0] ld_data,
   output logic        bad_f3
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   // Lane selection; funct3 4/5 on a store behave like byte/half by size bits.
   always_comb begin
      byte_v  = rword[{offset, 3'b000} +: 8];
      half_v  = offset[1] ? rword[31:16] : rword[15:0];
      be      = 4'b0000;
      st_word = 32'h0000_0000;
      ld_data = 32'h0000_0000;
      bad_f3  = is_reserved_f3(func3);
      case (func3)
         F3_B: begin
            be      = 4'b0001 << offset;
            st_word = {4{wdata[7:0]}};
            ld_data = {{24{byte_v[7]}}, byte_v};
         end
         F3_BU: begin
            be      = 4'b0001 << offset;
            st_word = {4{wdata[7:0]}};
            ld_data = {24'h00_0000, byte_v};
         end
         F3_H: begin
            be      = 4'b0011 << {offset[1], 1'b0};
            st_word = {2{wdata[15:0]}};
            ld_data = {{16{half_v[15]}}, half_v};
         end
         F3_HU: begin
            be      = 4'b0011 << {offset[1], 1'b0};
            st_word = {2{wdata[15:0]}};
            ld_data = {16'h0000, half_v};
         end
         F3_W: begin
            be      = 4'b1111;
            st_word = wdata;
            ld_data = rword;
         end
         default: begin
            be      = 4'b0000;
            st_word = 32'h0000_0000;
            ld_data = 32'h0000_0000;
         end
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder with programmable wait states and a
// pipeline stall. Optional DMEM_MISALIGN_ERR_EN adds rd_err for misaligned/reserved accesses.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DM_ADDRESS  = DMEM_ADDR_W,
   parameter int DATA_W      = 32,
   parameter int WAIT_STATES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  MemRead,
   input  logic                  MemWrite,
   input  logic [DM_ADDRESS-1:0] addr,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic [2:0]            func3,
   output logic                  stall,
   output logic                  rd_valid,
`ifdef DMEM_MISALIGN_ERR_EN
   output logic                  rd_err,
`endif
   output logic [DATA_W-1:0]     rd_data
);

   localparam int WORDS = 2 ** (DM_ADDRESS - 2);

   dmem_state_t state_r, state_d;
   logic [3:0]  cnt_r, cnt_d;
   dmem_req_t   req_r, req_d;

   logic [31:0] mem [0:WORDS-1];
   logic [DM_ADDRESS-3:0] widx;
   logic [31:0] rword;
   logic [31:0] st_word;
   logic [31:0] ld_data;
   logic [3:0]  be;
   logic        bad_f3;
   logic        suppress;
   logic        commit;
   logic        rd_valid_r;
   logic [31:0] rd_data_r;

   assign widx   = req_r.addr[DM_ADDRESS-1:2];
   assign rword  = mem[widx];
   assign commit = (state_r == BUSY) && (cnt_r == 4'd0);

   dmem_lane_fmt u_lane_fmt (
      .offset  (req_r.addr[1:0]),
      .func3   (req_r.func3),
      .wdata   (req_r.wdata),
      .rword   (rword),
      .be      (be),
      .st_word (st_word),
      .ld_data (ld_data),
      .bad_f3  (bad_f3)
   );

`ifdef DMEM_MISALIGN_ERR_EN
   logic misaligned;
   logic rd_err_r;
   assign misaligned = (((req_r.func3 == F3_H) || (req_r.func3 == F3_HU)) && req_r.addr[0]) ||
                       ((req_r.func3 == F3_W) && (req_r.addr[1:0] != 2'b00));
   assign suppress   = bad_f3 | misaligned;
   assign rd_err     = rd_err_r;
`else
   assign suppress   = bad_f3;
`endif

   // Next-state, request capture and the combinational stall.
   always_comb begin
      state_d = state_r;
      cnt_d   = cnt_r;
      req_d   = req_r;
      stall   = 1'b0;
      case (state_r)
         IDLE: begin
            if (MemRead | MemWrite) begin
               stall          = 1'b1;
               state_d        = BUSY;
               cnt_d          = 4'(WAIT_STATES);
               req_d.is_write = MemWrite;
               req_d.addr     = addr;
               req_d.wdata    = wr_data;
               req_d.func3    = func3;
            end else begin
               state_d = IDLE;
            end
         end
         BUSY: begin
            stall = 1'b1;
            if (cnt_r != 4'd0) begin
               cnt_d = cnt_r - 4'd1;
            end else begin
               state_d = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Control state and the registered response.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r    <= IDLE;
         cnt_r      <= 4'd0;
         req_r      <= '0;
         rd_valid_r <= 1'b0;
         rd_data_r  <= 32'h0000_0000;
`ifdef DMEM_MISALIGN_ERR_EN
         rd_err_r   <= 1'b0;
`endif
      end else begin
         state_r    <= state_d;
         cnt_r      <= cnt_d;
         req_r      <= req_d;
         rd_valid_r <= commit;
         if (commit) begin
            rd_data_r <= (req_r.is_write || suppress) ? 32'h0000_0000 : ld_data;
`ifdef DMEM_MISALIGN_ERR_EN
            rd_err_r  <= suppress;
`endif
         end
      end
   end

   // Byte-enabled array write; reset on the commit edge still cancels the store.
   always_ff @(posedge clk) begin
      if (commit && !reset && req_r.is_write && !suppress) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
               mem[widx][8*i +: 8] <= st_word[8*i +: 8];
            end
         end
      end
   end

   assign rd_valid = rd_valid_r;
   assign rd_data  = rd_data_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, reset corner
// sequences and randomized accesses against an array-based reference model.
module tb_dmem_responder;

   localparam int WS = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemRead;
   logic        MemWrite;
   logic [8:0]  addr;
   logic [31:0] wr_data;
   logic [2:0]  func3;
   logic        stall;
   logic        rd_valid;
   logic [31:0] rd_data;
`ifdef DMEM_MISALIGN_ERR_EN
   logic        rd_err;
`endif

   int checks   = 0;
   int failures = 0;

   logic [31:0] model_mem [128];

   dmem_responder #(.DM_ADDRESS(9), .DATA_W(32), .WAIT_STATES(WS)) dut (
      .clk      (clk),
      .reset    (reset),
      .MemRead  (MemRead),
      .MemWrite (MemWrite),
      .addr     (addr),
      .wr_data  (wr_data),
      .func3    (func3),
      .stall    (stall),
      .rd_valid (rd_valid),
`ifdef DMEM_MISALIGN_ERR_EN
      .rd_err   (rd_err),
`endif
      .rd_data  (rd_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [8:0]  a;
      logic [31:0] d;
      logic [2:0]  f;
      logic [31:0] exp_d;
      logic        exp_e;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   function automatic logic model_err(input logic [8:0] a, input logic [2:0] f);
      int fi = int'(f);
      if (fi == 3 || fi == 6 || fi == 7) return 1'b1;
`ifdef DMEM_MISALIGN_ERR_EN
      if ((fi == 1 || fi == 5) && (a % 2 != 0)) return 1'b1;
      if (fi == 2 && (a % 4 != 0)) return 1'b1;
`endif
      return 1'b0;
   endfunction

   function automatic logic [31:0] model_load(input logic [8:0] a, input logic [2:0] f);
      logic [31:0] w = model_mem[a / 4];
      logic [31:0] v;
      int fi = int'(f);
      if (model_err(a, f)) return 32'h0;
      if (fi % 4 == 0) begin
         v = (w >> (8 * (a % 4))) & 32'hFF;
         if (fi == 0 && v >= 32'd128) v = v | 32'hFFFF_FF00;
      end else if (fi % 4 == 1) begin
         v = (w >> (16 * ((a / 2) % 2))) & 32'hFFFF;
         if (fi == 1 && v >= 32'd32768) v = v | 32'hFFFF_0000;
      end else begin
         v = w;
      end
      return v;
   endfunction

   task automatic model_store(input logic [8:0] a, input logic [31:0] d, input logic [2:0] f);
      logic [31:0] mask;
      int sh;
      int fi = int'(f);
      if (model_err(a, f)) return;
      if (fi % 4 == 0) begin
         sh = 8 * (a % 4);
         mask = 32'hFF << sh;
      end else if (fi % 4 == 1) begin
         sh = 16 * ((a / 2) % 2);
         mask = 32'hFFFF << sh;
      end else begin
         sh = 0;
         mask = 32'hFFFF_FFFF;
      end
      model_mem[a / 4] = (model_mem[a / 4] & ~mask) | ((d << sh) & mask);
   endtask

   // One full access starting at posedge+1 in IDLE; checks latency, stall length and response.
   task automatic run(input logic r, input logic w, input logic [8:0] a, input logic [31:0] d,
                      input logic [2:0] f, input logic [31:0] exp_d, input logic exp_e, input string tag);
      int lat = -1;
      int stalls = 0;
      logic [31:0] got = 32'h0;
      logic got_e = 1'b0;
      MemRead = r; MemWrite = w; addr = a; wr_data = d; func3 = f;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (stall) stalls++;
         if (rd_valid) begin
            got = rd_data;
`ifdef DMEM_MISALIGN_ERR_EN
            got_e = rd_err;
`endif
            lat = c;
            break;
         end
      end
      MemRead = 1'b0; MemWrite = 1'b0;
      chk({tag, " latency"}, lat, WS + 2);
      chk({tag, " stall_cycles"}, stalls, WS + 2);
      chk({tag, " rd_data"}, got, exp_d);
`ifdef DMEM_MISALIGN_ERR_EN
      chk({tag, " rd_err"}, {31'd0, got_e}, {31'd0, exp_e});
`else
      if (got_e !== 1'b0 && exp_e === 1'b1) $display("note: err flag unused");
`endif
      if (w) model_store(a, d, f);
      @(posedge clk); #1;
   endtask

   vec_t vecs [$];

   initial begin
      logic [31:0] rd_d;
      logic        seen;
      int          kind;
      logic [8:0]  ra;
      logic [2:0]  rf;
      logic [31:0] rdw;

      vecs.push_back('{1'b0, 1'b1, 9'h010, 32'hDEAD_BEEF, 3'd2, 32'h0, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 9'h010, 32'h0,         3'd2, 32'hDEAD_BEEF, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 9'h005, 32'h0000_0080, 3'd0, 32'h0, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 9'h005, 32'h0,         3'd0, 32'hFFFF_FF80, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 9'h005, 32'h0,         3'd4, 32'h0000_0080, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 9'h004, 32'h0,         3'd2, 32'h0000_8000, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 9'h00A, 32'h1234_ABCD, 3'd1, 32'h0, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 9'h00A, 32'h0,         3'd1, 32'hFFFF_ABCD, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 9'h00A, 32'h0,         3'd5, 32'h0000_ABCD, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 9'h008, 32'h0,         3'd2, 32'hABCD_0000, 1'b0});
      vecs.push_back('{1'b1, 1'b1, 9'h030, 32'h0000_0011, 3'd2, 32'h0, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 9'h030, 32'h0,         3'd2, 32'h0000_0011, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 9'h013, 32'h0,         3'd0, 32'hFFFF_FFDE, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 9'h012, 32'h0,         3'd5, 32'h0000_DEAD, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 9'h010, 32'hFFFF_FFFF, 3'd3, 32'h0, 1'b1});
      vecs.push_back('{1'b1, 1'b0, 9'h010, 32'h0,         3'd2, 32'hDEAD_BEEF, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 9'h010, 32'h0,         3'd6, 32'h0, 1'b1});
      vecs.push_back('{1'b0, 1'b1, 9'h1FC, 32'h1357_9BDF, 3'd2, 32'h0, 1'b0});
      vecs.push_back('{1'b1, 1'b0, 9'h1FC, 32'h0,         3'd2, 32'h1357_9BDF, 1'b0});
      vecs.push_back('{1'b0, 1'b1, 9'h000, 32'hCAFE_F00D, 3'd2, 32'h0, 1'b0});
`ifdef DMEM_MISALIGN_ERR_EN
      vecs.push_back('{1'b1, 1'b0, 9'h003, 32'h0,         3'd2, 32'h0, 1'b1});
      vecs.push_back('{1'b0, 1'b1, 9'h001, 32'h0000_7777, 3'd1, 32'h0, 1'b1});
      vecs.push_back('{1'b1, 1'b0, 9'h000, 32'h0,         3'd2, 32'hCAFE_F00D, 1'b0});
`else
      vecs.push_back('{1'b1, 1'b0, 9'h003, 32'h0,         3'd2, 32'hCAFE_F00D, 1'b0});
`endif

      reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; addr = 9'h0; wr_data = 32'h0; func3 = 3'd0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("reset stall", {31'd0, stall}, 32'd0);
      chk("reset rd_valid", {31'd0, rd_valid}, 32'd0);
      chk("reset rd_data", rd_data, 32'h0);
      @(posedge clk); #1;

      for (int i = 0; i < 128; i++) model_mem[i] = 32'h0;
      for (int i = 0; i < 128; i++) run(1'b0, 1'b1, 9'(i * 4), 32'h0, 3'd2, 32'h0, 1'b0, "init");

      for (int i = 0; i < vecs.size(); i++)
         run(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].f,
             vecs[i].exp_d, vecs[i].exp_e, $sformatf("vec%0d", i));

      // Reset during the second BUSY cycle cancels the store.
      MemWrite = 1'b1; addr = 9'h020; wr_data = 32'h55; func3 = 3'd2;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1; MemWrite = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("busy_reset stall", {31'd0, stall}, 32'd0);
      chk("busy_reset rd_valid", {31'd0, rd_valid}, 32'd0);
      seen = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (rd_valid) seen = 1'b1;
      end
      chk("busy_reset no_pulse", {31'd0, seen}, 32'd0);
      @(posedge clk); #1;
      run(1'b1, 1'b0, 9'h020, 32'h0, 3'd2, model_load(9'h020, 3'd2), 1'b0, "busy_reset readback");

      // Reset in RESP: store already committed, pulse dropped.
      MemWrite = 1'b1; addr = 9'h024; wr_data = 32'h77; func3 = 3'd2;
      seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (rd_valid) begin seen = 1'b1; break; end
      end
      chk("resp_reset reached", {31'd0, seen}, 32'd1);
      reset = 1'b1; MemWrite = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("resp_reset rd_valid", {31'd0, rd_valid}, 32'd0);
      model_store(9'h024, 32'h77, 3'd2);
      @(posedge clk); #1;
      run(1'b1, 1'b0, 9'h024, 32'h0, 3'd2, 32'h0000_0077, 1'b0, "resp_reset readback");

      for (int n = 0; n < 200; n++) begin
         kind = $urandom_range(0, 2);
         ra   = 9'($urandom);
         rf   = 3'($urandom_range(0, 7));
         rdw  = $urandom;
         rd_d = (kind == 0) ? model_load(ra, rf) : 32'h0;
         run(kind != 1, kind != 0, ra, rdw, rf, rd_d, model_err(ra, rf), $sformatf("rand%0d", n));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
